// File: rtl/arithmetic_dispatch_if.sv
// Bundle of the fetch, register-file, arithmetic and writeback signals of the
// arithmetic dispatcher. The master side is the dispatcher itself.
interface arithmetic_dispatch_if #(
  parameter int unsigned COUNT_WIDTH = 16
);
  logic [31:0]            instruction;
  logic                   instruction_valid;
  logic                   instruction_ready;
  logic [4:0]             rs1_addr;
  logic [4:0]             rs2_addr;
  logic                   read_enable;
  logic [31:0]            rs1_data;
  logic [31:0]            rs2_data;
  logic [31:0]            lhs;
  logic                   lhs_valid;
  logic [31:0]            rhs;
  logic                   rhs_valid;
  logic [2:0]             operation;
  logic                   operation_valid;
  logic [6:0]             metadata;
  logic                   metadata_valid;
  logic [31:0]            result;
  logic                   arithmetic_code_legal;
  logic                   result_valid;
  logic [4:0]             rd_addr;
  logic [31:0]            rd_data;
  logic                   rd_write;
  logic                   writeback_ready;
  logic                   illegal;
  logic [COUNT_WIDTH-1:0] retired_count;

  modport master (
    input  instruction, instruction_valid, rs1_data, rs2_data,
           result, arithmetic_code_legal, result_valid, writeback_ready,
    output instruction_ready, rs1_addr, rs2_addr, read_enable,
           lhs, lhs_valid, rhs, rhs_valid, operation, operation_valid,
           metadata, metadata_valid, rd_addr, rd_data, rd_write,
           illegal, retired_count
  );

  modport slave (
    output instruction, instruction_valid, rs1_data, rs2_data,
           result, arithmetic_code_legal, result_valid, writeback_ready,
    input  instruction_ready, rs1_addr, rs2_addr, read_enable,
           lhs, lhs_valid, rhs, rhs_valid, operation, operation_valid,
           metadata, metadata_valid, rd_addr, rd_data, rd_write,
           illegal, retired_count
  );
endinterface

// File: rtl/arithmetic_dispatch.sv
// Front-end driver for the arithmetic unit: accepts RV32I OP / OP-IMM words,
// fetches operands from the register file, presents them to the arithmetic
// unit and turns its answer into a register writeback or an illegal pulse.
module arithmetic_dispatch #(
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  arithmetic_dispatch_if.master bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    EXECUTE,
    WRITEBACK,
    ILLEGAL
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            instr_q;
  logic [31:0]            lhs_q, rhs_q;
  logic [2:0]             op_q;
  logic [6:0]             meta_q;
  logic [4:0]             rd_addr_q;
  logic [31:0]            rd_data_q;
  logic [COUNT_WIDTH-1:0] retired_q;

  logic ready, read_en, exec_valid, wr, ill, retire, capture;
  logic accept_arith;

  assign accept_arith = (bus.instruction[6:0] == OPC_OP) ||
                        (bus.instruction[6:0] == OPC_OP_IMM);

  // Next-state and per-state strobes.
  always_comb begin
    state_d    = state_q;
    ready      = 1'b0;
    read_en    = 1'b0;
    exec_valid = 1'b0;
    wr         = 1'b0;
    ill        = 1'b0;
    retire     = 1'b0;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.instruction_valid) state_d = accept_arith ? READ : ILLEGAL;
      end
      READ: begin
        read_en = 1'b1;
        state_d = LOAD;
      end
      LOAD: state_d = EXECUTE;
      EXECUTE: begin
        exec_valid = 1'b1;
        if (!bus.arithmetic_code_legal) begin
          state_d = ILLEGAL;
        end else if (bus.result_valid) begin
          if (instr_q[11:7] == 5'd0) begin
            retire  = 1'b1;
            state_d = IDLE;
          end else begin
            capture = 1'b1;
            state_d = WRITEBACK;
          end
        end
      end
      WRITEBACK: begin
        wr = 1'b1;
        if (bus.writeback_ready) begin
          retire  = 1'b1;
          state_d = IDLE;
        end
      end
      ILLEGAL: begin
        ill     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Latch the instruction on the accept handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                          instr_q <= '0;
    else if (state_q == IDLE && bus.instruction_valid) instr_q <= bus.instruction;
  end

  // Operand capture in LOAD; register data is only valid in this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lhs_q  <= '0;
      rhs_q  <= '0;
      op_q   <= '0;
      meta_q <= '0;
    end else if (state_q == LOAD) begin
      lhs_q <= bus.rs1_data;
      op_q  <= instr_q[14:12];
      if (instr_q[6:0] == OPC_OP) begin
        rhs_q  <= bus.rs2_data;
        meta_q <= instr_q[31:25];
      end else if (instr_q[14:12] == 3'd1 || instr_q[14:12] == 3'd5) begin
        // Shift-immediates keep funct7 so the unit can tell SRLI from SRAI.
        rhs_q  <= {27'b0, instr_q[24:20]};
        meta_q <= instr_q[31:25];
      end else begin
        rhs_q  <= {{20{instr_q[31]}}, instr_q[31:20]};
        meta_q <= '0;
      end
    end
  end

  // Writeback address/data, held stable until the write is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else if (capture) begin
      rd_addr_q <= instr_q[11:7];
      rd_data_q <= bus.result;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        retired_q <= '0;
    else if (retire) retired_q <= retired_q + 1'b1;
  end

  assign bus.instruction_ready = ready;
  assign bus.rs1_addr          = instr_q[19:15];
  assign bus.rs2_addr          = instr_q[24:20];
  assign bus.read_enable       = read_en;
  assign bus.lhs               = lhs_q;
  assign bus.rhs               = rhs_q;
  assign bus.operation         = op_q;
  assign bus.metadata          = meta_q;
  assign bus.lhs_valid         = exec_valid;
  assign bus.rhs_valid         = exec_valid;
  assign bus.operation_valid   = exec_valid;
  assign bus.metadata_valid    = exec_valid;
  assign bus.rd_addr           = rd_addr_q;
  assign bus.rd_data           = rd_data_q;
  assign bus.rd_write          = wr;
  assign bus.illegal           = ill;
  assign bus.retired_count     = retired_q;

endmodule
